// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Non-pipelined instruction fetch stage sitting directly in front of the control unit.
//   It holds the PC and fetches one word at a time from the instruction ROM over a
//   req/valid handshake. It presents that word for one EXEC cycle, then uses the decoded
//   control outputs to choose the next PC.
//
//   Ports
//     clock, reset       rising-edge clock; asynchronous active-high reset
//     romReq, romAddr    ROM read request and address (address is always the current pc)
//     _romData/_romValid ROM response; the data is captured only while waiting for it
//     instruction        registered instruction word; insnValid marks the EXEC cycle
//     _halt.._compare    decoded control from the control unit, sampled at the end of EXEC
//     _start             resume pulse out of HALTED
//     pc, halted         current program counter and halt status
//     insnCount          retired-instruction counter, saturating
module instruction_fetch #(
    parameter int PC_WIDTH   = 8,
    parameter int RESET_PC   = 0,
    parameter int CNT_WIDTH  = 16,
    parameter int INSN_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  romReq,
    output logic [PC_WIDTH-1:0]   romAddr,
    input  logic [INSN_WIDTH-1:0] _romData,
    input  logic                  _romValid,
    output logic [INSN_WIDTH-1:0] instruction,
    output logic                  insnValid,
    input  logic                  _halt,
    input  logic                  _branch,
    input  logic                  _jump,
    input  logic                  _relative,
    input  logic [DATA_WIDTH-1:0] _destBranchJump,
    input  logic                  _compare,
    input  logic                  _start,
    output logic [PC_WIDTH-1:0]   pc,
    output logic                  halted,
    output logic [CNT_WIDTH-1:0]  insnCount
);

    localparam logic [PC_WIDTH-1:0] RESET_PC_L = PC_WIDTH'(RESET_PC);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_WAIT   = 2'd1,
        S_EXEC   = 2'd2,
        S_HALTED = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [PC_WIDTH-1:0]     pc_q, pc_d;
    logic [INSN_WIDTH-1:0]   insn_q, insn_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

    logic [PC_WIDTH-1:0]     offset_ext;
    logic [PC_WIDTH-1:0]     abs_target;
    logic [PC_WIDTH-1:0]     target;
    logic [PC_WIDTH-1:0]     pc_inc;

    // Offset is two's complement. When it is at least as wide as the PC, the bits above
    // PC_WIDTH cannot affect a modulo-2^PC_WIDTH sum, so truncation is exact.
    generate
        if (DATA_WIDTH >= PC_WIDTH) begin : g_wide_dest
            assign offset_ext = _destBranchJump[PC_WIDTH-1:0];
            assign abs_target = _destBranchJump[PC_WIDTH-1:0];
        end else begin : g_narrow_dest
            assign offset_ext = {{(PC_WIDTH-DATA_WIDTH){_destBranchJump[DATA_WIDTH-1]}}, _destBranchJump};
            assign abs_target = {{(PC_WIDTH-DATA_WIDTH){1'b0}}, _destBranchJump};
        end
    endgenerate

    assign pc_inc = pc_q + PC_WIDTH'(1);
    assign target = _relative ? (pc_q + offset_ext) : abs_target;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        insn_d  = insn_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                if (_romValid) begin
                    insn_d  = _romData;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                cnt_d   = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + CNT_WIDTH'(1);
                state_d = S_FETCH;
                // Halt outranks jump, and jump outranks a taken branch.
                if (_halt) begin
                    pc_d    = pc_inc;
                    state_d = S_HALTED;
                end else if (_jump) begin
                    pc_d = target;
                end else if (_branch && _compare) begin
                    pc_d = target;
                end else begin
                    pc_d = pc_inc;
                end
            end
            S_HALTED: begin
                if (_start) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC_L;
            insn_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            insn_q  <= insn_d;
            cnt_q   <= cnt_d;
        end
    end

    // The request is decoded from the state so that a 1-cycle ROM can answer during the
    // first WAIT cycle. Reset lands in FETCH, so the request is also masked by reset to
    // keep it low while reset is held.
    assign romReq      = ~reset & ((state_q == S_FETCH) | (state_q == S_WAIT));
    assign romAddr     = pc_q;
    assign pc          = pc_q;
    assign instruction = insn_q;
    assign insnValid   = (state_q == S_EXEC);
    assign halted      = (state_q == S_HALTED);
    assign insnCount   = cnt_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a ROM responder with programmable latency, a combinational
// control-unit decode of the instruction word, an instruction-level reference model that
// is checked every cycle, and directed scenarios with literal expectations.
module tb_instruction_fetch;

    localparam int CW = 4;  // small counter so saturation is reached quickly

    // Instruction word layout used by this bench's control-unit decode
    localparam logic [15:0] OP_H = 16'h8000;
    localparam logic [15:0] OP_J = 16'h4000;
    localparam logic [15:0] OP_B = 16'h2000;
    localparam logic [15:0] OP_R = 16'h1000;
    localparam logic [15:0] OP_C = 16'h0800;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          romReq;
    logic [7:0]    romAddr;
    logic [15:0]   romData = '0;
    logic          romValid = 1'b0;
    logic [15:0]   instruction;
    logic          insnValid;
    logic          c_halt, c_branch, c_jump, c_rel, c_cmp;
    logic [7:0]    c_dest;
    logic          start = 1'b0;
    logic [7:0]    pc;
    logic          halted;
    logic [CW-1:0] insnCount;

    logic [15:0]   rom [256];
    int            rom_lat = 1;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;

    // Reference model state (instruction level)
    int            mpc = 0;
    int            mcnt = 0;
    bit            mhalt = 1'b0;

    instruction_fetch #(
        .PC_WIDTH(8), .RESET_PC(0), .CNT_WIDTH(CW), .INSN_WIDTH(16), .DATA_WIDTH(8)
    ) dut (
        .clock(clock), .reset(reset),
        .romReq(romReq), .romAddr(romAddr), ._romData(romData), ._romValid(romValid),
        .instruction(instruction), .insnValid(insnValid),
        ._halt(c_halt), ._branch(c_branch), ._jump(c_jump), ._relative(c_rel),
        ._destBranchJump(c_dest), ._compare(c_cmp), ._start(start),
        .pc(pc), .halted(halted), .insnCount(insnCount)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Control unit: decodes combinationally from the presented word
    assign c_halt   = instruction[15];
    assign c_jump   = instruction[14];
    assign c_branch = instruction[13];
    assign c_rel    = instruction[12];
    assign c_cmp    = instruction[11];
    assign c_dest   = instruction[7:0];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ROM: looks at the request just before each edge, answers after rom_lat requesting
    // cycles with a single-cycle valid pulse.
    initial begin
        int cnt = 0;
        bit r;
        forever begin
            @(negedge clock);
            r = romReq;
            @(posedge clock);
            #1;
            if (reset) begin
                romValid = 1'b0;
                cnt = 0;
            end else if (romValid) begin
                romValid = 1'b0;
                cnt = 0;
            end else if (r) begin
                cnt++;
                if (cnt >= rom_lat) begin
                    romValid = 1'b1;
                    romData  = rom[romAddr];
                end
            end
        end
    end

    // Every-cycle comparison against the instruction-level model
    always @(negedge clock) begin
        logic [15:0] w;
        int off, tgt;
        if (reset) begin
            mpc = 0; mcnt = 0; mhalt = 1'b0;
        end else begin
            chk("halted", halted, mhalt);
            chk("pc", pc, mpc);
            chk("insnCount", insnCount, mcnt);
            if (romReq) chk("romAddr", romAddr, mpc);
            if (mhalt) chk("romReq_in_halt", romReq, 0);
            if (insnValid) begin
                w = rom[mpc];
                chk("instruction", instruction, w);
                chk("romReq_in_exec", romReq, 0);
                off = w[7] ? int'(w[7:0]) - 256 : int'(w[7:0]);
                tgt = w[12] ? (mpc + off + 256) % 256 : int'(w[7:0]);
                if (w[15]) begin
                    mpc = (mpc + 1) % 256; mhalt = 1'b1;
                end else if (w[14]) mpc = tgt;
                else if (w[13] && w[11]) mpc = tgt;
                else mpc = (mpc + 1) % 256;
                if (mcnt < (1 << CW) - 1) mcnt++;
            end else if (mhalt && start) begin
                mhalt = 1'b0;
            end
        end
    end

    task automatic wait_exec_at(input int a, output int at);
        bit got = 1'b0;
        at = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clock);
            if (insnValid && pc == a[7:0]) begin
                got = 1'b1;
                at = cyc;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL wait_exec pc=%0h actual=timeout expected=exec", a);
        end
    endtask

    initial begin
        int c0, c1, c2, n;
        #100000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, c2, n, dummy;
        for (int i = 0; i < 256; i++) rom[i] = 16'h0100 | 16'(i);
        rom[8'h05] = OP_J | 16'h0020;
        rom[8'h20] = OP_J | 16'h0010;
        rom[8'h10] = OP_B | OP_R | OP_C | 16'h00FC;
        rom[8'h0C] = OP_J | 16'h0010;
        rom[8'h11] = OP_J | OP_B | 16'h00FF;
        rom[8'hFF] = 16'h01FF;

        // Reset values
        repeat (2) @(posedge clock);
        #1;
        chk("rst_romReq", romReq, 0);
        chk("rst_insnValid", insnValid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pc", pc, 0);
        chk("rst_cnt", insnCount, 0);
        chk("rst_instruction", instruction, 0);
        #1 reset = 1'b0;
        #1 chk("fetch0_addr", romAddr, 0);

        // T1: sequential fetch, one instruction every 3 cycles
        wait_exec_at(0, c0);
        wait_exec_at(1, c1);
        wait_exec_at(2, c2);
        chk("t1_gap01", c1 - c0, 3);
        chk("t1_gap12", c2 - c1, 3);
        @(posedge clock); #1;
        chk("t1_cnt", insnCount, 3);
        // _start outside HALTED must be ignored (model checks the flow continues)
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;

        // T2: absolute jump from 5 to 0x20
        wait_exec_at(5, dummy);
        @(posedge clock); #1;
        chk("t2_addr", romAddr, 8'h20);
        chk("t2_req", romReq, 1);
        chk("t2_cnt", insnCount, 6);

        // T3: relative branch taken, then not taken, at 0x10
        wait_exec_at(8'h20, dummy);
        wait_exec_at(8'h10, dummy);
        @(posedge clock); #1;
        chk("t3_taken_pc", pc, 8'h0C);
        rom[8'h10] = OP_B | OP_R | 16'h00FC;
        wait_exec_at(8'h0C, dummy);
        wait_exec_at(8'h10, dummy);
        @(posedge clock); #1;
        chk("t3_nottaken_pc", pc, 8'h11);

        // T4: jump wins over branch, wrap at 0xFF, halt wins over jump
        rom[8'h03] = OP_H | OP_J | 16'h0077;
        wait_exec_at(8'h11, dummy);
        wait_exec_at(8'hFF, dummy);
        @(posedge clock); #1;
        chk("t4_wrap_pc", pc, 8'h00);
        wait_exec_at(3, dummy);
        @(posedge clock); #1;
        chk("t4_halted", halted, 1);
        chk("t4_halt_pc", pc, 8'h04);
        chk("t4_halt_req", romReq, 0);
        repeat (3) @(posedge clock);
        #1;
        chk("t4_still_halted", halted, 1);
        chk("t4_frozen_pc", pc, 8'h04);

        // T5: resume into a 5-cycle ROM stall
        rom_lat = 5;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        chk("t5_resume_req", romReq, 1);
        chk("t5_resume_addr", romAddr, 8'h04);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (insnValid) break;
            if (romReq && romAddr == 8'h04) n++;
        end
        chk("t5_req_cycles", n, 6);
        chk("t5_insn", instruction, 16'h0104);
        chk("t5_cnt_sat", insnCount, 15);

        // Reset in the middle of WAIT
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("t5_in_wait_req", romReq, 1);
        #1 reset = 1'b1;
        #1;
        chk("t5_rst_req", romReq, 0);
        chk("t5_rst_pc", pc, 0);
        chk("t5_rst_valid", insnValid, 0);
        chk("t5_rst_halted", halted, 0);
        chk("t5_rst_cnt", insnCount, 0);
        chk("t5_rst_insn", instruction, 0);
        rom_lat = 1;
        @(posedge clock); #2;
        reset = 1'b0;
        #1;
        chk("t5_refetch_req", romReq, 1);
        chk("t5_refetch_addr", romAddr, 0);
        wait_exec_at(0, dummy);
        wait_exec_at(1, dummy);
        @(posedge clock); #1;
        chk("t5_cnt_after", insnCount, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
